// File: rtl/tlb_pkg.sv
// Shared constants for the CP0 TLB operation sequencer: op codes, FSM states,
// packed TLB entry layout and CP0 EntryHi/EntryLo field positions.
package tlb_pkg;

  // CP0 TLB instruction codes as presented on op_code
  localparam logic [1:0] OP_TLBP  = 2'd0;
  localparam logic [1:0] OP_TLBR  = 2'd1;
  localparam logic [1:0] OP_TLBWI = 2'd2;
  localparam logic [1:0] OP_TLBWR = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // Packed entry {vpn2, asid, g, pfn0, c0, d0, v0, pfn1, c1, d1, v1}
  localparam int TLB_ENTRY_W = 78;
  localparam int VPN2_W      = 19;
  localparam int ASID_W      = 8;
  localparam int PFN_W       = 20;
  localparam int C_W         = 3;

  localparam int E_V1   = 0;
  localparam int E_D1   = 1;
  localparam int E_C1   = 2;
  localparam int E_PFN1 = 5;
  localparam int E_V0   = 25;
  localparam int E_D0   = 26;
  localparam int E_C0   = 27;
  localparam int E_PFN0 = 30;
  localparam int E_G    = 50;
  localparam int E_ASID = 51;
  localparam int E_VPN2 = 59;

  // CP0 EntryHi / EntryLo field positions
  localparam int EH_VPN2_LSB = 13;
  localparam int EH_ASID_LSB = 0;
  localparam int EL_PFN_LSB  = 6;
  localparam int EL_C_LSB    = 3;
  localparam int EL_D        = 2;
  localparam int EL_V        = 1;
  localparam int EL_G        = 0;

  // Rebuild a CP0 EntryLo word from TLB entry fields
  function automatic logic [31:0] make_entrylo(input logic [PFN_W-1:0] pfn,
                                               input logic [C_W-1:0]   c,
                                               input logic             d,
                                               input logic             v,
                                               input logic             g);
    return {6'b0, pfn, c, d, v, g};
  endfunction

endpackage

// File: rtl/tlb_random_ctr.sv
// CP0 Random register: free-running down-counter bounded below by Wired,
// restarting at TLBNUM-1. Only built when TLB_CTRL_RANDOM_EN is defined.
module tlb_random_ctr
  import tlb_pkg::*;
#(
  parameter  int TLBNUM = 16,
  localparam int IW     = $clog2(TLBNUM)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [IW-1:0] wired,
  output logic [IW-1:0] random
);

  localparam logic [IW-1:0] TOP = IW'(TLBNUM - 1);

  logic [IW-1:0] random_q, random_d;
  logic [IW-1:0] wired_q;

  // Next Random: restart on Wired change, on full Wired, or at the lower bound
  always_comb begin
    random_d = random_q - IW'(1);
    if ((wired != wired_q) || (wired == TOP) || (random_q <= wired)) begin
      random_d = TOP;
    end
  end

  // Counter and previous-Wired registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      random_q <= TOP;
      wired_q  <= '0;
    end else begin
      random_q <= random_d;
      wired_q  <= wired;
    end
  end

  assign random = random_q;

endmodule

// File: rtl/tlb_op_ctrl.sv
// Sequencer for TLBP/TLBR/TLBWI/TLBWR in front of the dual-search-port TLB.
// Owns search port 1, the read port and the write port; one op per 3 cycles.
// Optional macro TLB_CTRL_RANDOM_EN builds the Random counter used by TLBWR;
// without it Random reads TLBNUM-1 and TLBWR writes at index_in.
module tlb_op_ctrl
  import tlb_pkg::*;
#(
  parameter  int TLBNUM = 16,
  localparam int IW     = $clog2(TLBNUM)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   op_valid,
  output logic                   op_ready,
  input  logic [1:0]             op_code,
  input  logic [31:0]            entryhi,
  input  logic [31:0]            entrylo0,
  input  logic [31:0]            entrylo1,
  input  logic [IW-1:0]          index_in,
  input  logic [IW-1:0]          wired,
  output logic [IW-1:0]          random,
  output logic                   done,
  output logic [1:0]             res_op,
  output logic                   res_probe_miss,
  output logic [IW-1:0]          res_index,
  output logic [31:0]            res_entryhi,
  output logic [31:0]            res_entrylo0,
  output logic [31:0]            res_entrylo1,
  output logic [VPN2_W-1:0]      s1_vpn2,
  output logic                   s1_odd_page,
  output logic [ASID_W-1:0]      s1_asid,
  input  logic                   s1_found,
  input  logic [IW-1:0]          s1_index,
  output logic                   we,
  output logic [IW-1:0]          w_index,
  output logic [TLB_ENTRY_W-1:0] w_entry,
  output logic [IW-1:0]          r_index,
  input  logic [TLB_ENTRY_W-1:0] r_entry
);

  state_e                   state_q;
  logic [1:0]               op_q;
  logic                     done_q;
  logic [1:0]               res_op_q;
  logic                     res_probe_miss_q;
  logic [IW-1:0]            res_index_q;
  logic [31:0]              res_entryhi_q, res_entrylo0_q, res_entrylo1_q;
  logic [VPN2_W-1:0]        s1_vpn2_q;
  logic [ASID_W-1:0]        s1_asid_q;
  logic [IW-1:0]            r_index_q;
  logic                     we_q;
  logic [IW-1:0]            w_index_q;
  logic [TLB_ENTRY_W-1:0]   w_entry_q;
  logic [IW-1:0]            wr_index;
  logic [TLB_ENTRY_W-1:0]   new_entry;

`ifdef TLB_CTRL_RANDOM_EN
  tlb_random_ctr #(.TLBNUM(TLBNUM)) u_random (
    .clk    (clk),
    .reset  (reset),
    .wired  (wired),
    .random (random)
  );
  assign wr_index = random;
`else
  assign random   = IW'(TLBNUM - 1);
  assign wr_index = index_in;
  logic unused_wired;
  assign unused_wired = ^wired;
`endif

  // EntryHi[12:8] and EntryLo[31:26] carry no TLB state
  logic unused_fields;
  assign unused_fields = ^{entryhi[12:8], entrylo0[31:26], entrylo1[31:26]};

  // Entry image written by TLBWI/TLBWR; G is the AND of both EntryLo G bits
  assign new_entry = {entryhi[EH_VPN2_LSB +: VPN2_W], entryhi[EH_ASID_LSB +: ASID_W],
                      entrylo0[EL_G] & entrylo1[EL_G],
                      entrylo0[EL_PFN_LSB +: PFN_W], entrylo0[EL_C_LSB +: C_W],
                      entrylo0[EL_D], entrylo0[EL_V],
                      entrylo1[EL_PFN_LSB +: PFN_W], entrylo1[EL_C_LSB +: C_W],
                      entrylo1[EL_D], entrylo1[EL_V]};

  // Operation FSM: TLB-side outputs live only during EXEC, results load at RESP
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q          <= ST_IDLE;
      op_q             <= OP_TLBP;
      done_q           <= 1'b0;
      res_op_q         <= '0;
      res_probe_miss_q <= 1'b0;
      res_index_q      <= '0;
      res_entryhi_q    <= '0;
      res_entrylo0_q   <= '0;
      res_entrylo1_q   <= '0;
      s1_vpn2_q        <= '0;
      s1_asid_q        <= '0;
      r_index_q        <= '0;
      we_q             <= 1'b0;
      w_index_q        <= '0;
      w_entry_q        <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (op_valid) begin
            state_q <= ST_EXEC;
            op_q    <= op_code;
            case (op_code)
              OP_TLBP: begin
                s1_vpn2_q <= entryhi[EH_VPN2_LSB +: VPN2_W];
                s1_asid_q <= entryhi[EH_ASID_LSB +: ASID_W];
              end
              OP_TLBR: r_index_q <= index_in;
              default: begin
                we_q      <= 1'b1;
                w_index_q <= (op_code == OP_TLBWR) ? wr_index : index_in;
                w_entry_q <= new_entry;
              end
            endcase
          end
        end
        ST_EXEC: begin
          state_q   <= ST_RESP;
          s1_vpn2_q <= '0;
          s1_asid_q <= '0;
          r_index_q <= '0;
          we_q      <= 1'b0;
          w_index_q <= '0;
          w_entry_q <= '0;
          done_q    <= 1'b1;
          res_op_q  <= op_q;
          case (op_q)
            OP_TLBP: begin
              res_probe_miss_q <= ~s1_found;
              res_index_q      <= s1_found ? s1_index : '0;
            end
            OP_TLBR: begin
              res_entryhi_q  <= {r_entry[E_VPN2 +: VPN2_W], 5'b0, r_entry[E_ASID +: ASID_W]};
              res_entrylo0_q <= make_entrylo(r_entry[E_PFN0 +: PFN_W], r_entry[E_C0 +: C_W],
                                             r_entry[E_D0], r_entry[E_V0], r_entry[E_G]);
              res_entrylo1_q <= make_entrylo(r_entry[E_PFN1 +: PFN_W], r_entry[E_C1 +: C_W],
                                             r_entry[E_D1], r_entry[E_V1], r_entry[E_G]);
            end
            default: ;
          endcase
        end
        ST_RESP: begin
          state_q <= ST_IDLE;
          done_q  <= 1'b0;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign op_ready       = (state_q == ST_IDLE);
  assign done           = done_q;
  assign res_op         = res_op_q;
  assign res_probe_miss = res_probe_miss_q;
  assign res_index      = res_index_q;
  assign res_entryhi    = res_entryhi_q;
  assign res_entrylo0   = res_entrylo0_q;
  assign res_entrylo1   = res_entrylo1_q;
  assign s1_vpn2        = s1_vpn2_q;
  assign s1_odd_page    = 1'b0;
  assign s1_asid        = s1_asid_q;
  assign r_index        = r_index_q;
  assign we             = we_q;
  assign w_index        = w_index_q;
  assign w_entry        = w_entry_q;

endmodule
